mem_access_ctrl: RTL and testbench

- MEM-stage consumer of the EXE/MEM pipeline register outputs.
- Runs data-memory loads and stores over a req/ack handshake to a multi-cycle data memory.
- Asserts freeze to hold the EXE/MEM register and upstream stages while an access is outstanding.
- Presents write-back fields to the MEM/WB register.

---
 rtl/mem_access_ctrl_pkg.sv | 24 ++
 rtl/mem_access_ctrl_if.sv | 27 ++
 rtl/mem_access_ctrl_wait_timer.sv | 42 ++++
 rtl/mem_access_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mem_access_ctrl_pkg
// Purpose  : Shared MEM-stage constants, state encodings and address helper.
// Revision : 1.0
// ---------------------------------------------------------------------------
package mem_access_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam int DATA_BASE_DEF = 1024;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Byte address relative to the data segment, converted to a word index.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr,
                                            input logic [31:0] base);
    return (byte_addr - base) >> 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mem_access_ctrl_if
// Purpose  : req/ack bus between the MEM-stage controller and data memory.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl_wait_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mem_wait_timer
// Purpose  : Loadable wait counter flagging the last permitted BUSY cycle.
// Revision : 1.0
// ---------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic load_i,
  input  wire logic en_i,
  output logic      timeout_o
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i && !timeout_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the BUSY cycles already spent, so this is the TIMEOUT-th one.
  assign timeout_o = (count_q == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mem_access_ctrl
// Purpose  : MEM stage: drives loads/stores over req/ack and freezes the pipe.
// Revision : 1.0
// ---------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_BASE = DATA_BASE_DEF,
  parameter int ADDR_W    = 16,
  parameter int TIMEOUT   = 64
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         wb_en_in,
  input  wire logic         mem_r_en_in,
  input  wire logic         mem_w_en_in,
  input  wire logic [31:0]  alu_res_in,
  input  wire logic [31:0]  st_val_in,
  input  wire logic [4:0]   dest_in,
  output logic              freeze,
  mem_access_ctrl_if.master mem,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [31:0]       alu_res,
  output logic [31:0]       load_data,
  output logic [4:0]        dest,
  output logic              bus_err
);
  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       ldata_q, ldata_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;

  logic              w_access;
  logic              w_misaligned;
  logic [ADDR_W-1:0] w_waddr;
  logic              w_timer_load;
  logic              w_timeout;

  assign w_access     = mem_r_en_in | mem_w_en_in;
  assign w_misaligned = (alu_res_in[1:0] != 2'b00);
  assign w_waddr      = ADDR_W'(word_addr(alu_res_in, 32'(DATA_BASE)));

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (w_timer_load),
    .en_i      (state_q == ST_BUSY),
    .timeout_o (w_timeout)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ldata_d      = ldata_q;
    err_d        = err_q;
    abort_d      = abort_q;
    w_timer_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_access) begin
          if (w_misaligned) begin
            err_d   = 1'b1;
            ldata_d = '0;
            abort_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            req_d        = 1'b1;
            we_d         = mem_w_en_in;
            addr_d       = w_waddr;
            wdata_d      = st_val_in;
            abort_d      = 1'b0;
            w_timer_load = 1'b1;
            state_d      = ST_BUSY;
            // Conflicting r+w: the store wins but the instruction is flagged.
            if (mem_r_en_in && mem_w_en_in) begin
              err_d = 1'b1;
            end
          end
        end
      end
      ST_BUSY: begin
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
          if (!we_q) begin
            ldata_d = mem.mem_rdata;
          end
        end else if (w_timeout) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          ldata_d = '0;
          abort_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign freeze        = ((state_q == ST_IDLE) && w_access) || (state_q == ST_BUSY);
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  // An aborted load must not write its zeroed result into the register file.
  assign wb_en     = wb_en_in & ~((state_q == ST_DONE) & abort_q & mem_r_en_in);
  assign mem_r_en  = mem_r_en_in;
  assign alu_res   = alu_res_in;
  assign dest      = dest_in;
  assign load_data = ldata_q;
  assign bus_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench: transaction model plus per-cycle comparison.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;
  localparam int ADDR_W    = 16;
  localparam int TIMEOUT   = 64;
  localparam int DATA_BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, st_val_in;
  logic [4:0]  dest_in;
  logic        freeze, wb_en, mem_r_en, bus_err;
  logic [31:0] alu_res, load_data;
  logic [4:0]  dest;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  mem_access_ctrl #(
    .DATA_BASE (DATA_BASE),
    .ADDR_W    (ADDR_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_en_in    (wb_en_in),
    .mem_r_en_in (mem_r_en_in),
    .mem_w_en_in (mem_w_en_in),
    .alu_res_in  (alu_res_in),
    .st_val_in   (st_val_in),
    .dest_in     (dest_in),
    .freeze      (freeze),
    .mem         (bus),
    .wb_en       (wb_en),
    .mem_r_en    (mem_r_en),
    .alu_res     (alu_res),
    .load_data   (load_data),
    .dest        (dest),
    .bus_err     (bus_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Expected outputs for the current cycle, set by the stimulus from the model.
  logic        chk_en = 1'b0;
  logic        e_freeze = 1'b0, e_req = 1'b0, e_we = 1'b0, e_wb = 1'b0, e_rd = 1'b0, e_err = 1'b0;
  logic [15:0] e_addr = '0;
  logic [31:0] e_wdata = '0, e_alu = '0, e_ld = '0;
  logic [4:0]  e_dest = '0;

  // Behavioural model state.
  logic [31:0] mem_model [logic [15:0]];
  logic [31:0] m_ld  = '0;
  logic        m_err = 1'b0;
  logic [15:0] m_waddr;

  int          frz_cnt;
  logic [15:0] last_addr;
  logic [31:0] last_wdata;
  logic        last_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("freeze",    32'(freeze),       32'(e_freeze));
      check("mem_req",   32'(bus.mem_req),  32'(e_req));
      check("wb_en",     32'(wb_en),        32'(e_wb));
      check("mem_r_en",  32'(mem_r_en),     32'(e_rd));
      check("alu_res",   alu_res,           e_alu);
      check("dest",      32'(dest),         32'(e_dest));
      check("load_data", load_data,         e_ld);
      check("bus_err",   32'(bus_err),      32'(e_err));
      if (e_req) begin
        check("mem_we",    32'(bus.mem_we),   32'(e_we));
        check("mem_addr",  32'(bus.mem_addr), 32'(e_addr));
        check("mem_wdata", bus.mem_wdata,     e_wdata);
      end
    end
  end

  function automatic logic [31:0] rd_mem(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {16'hC0DE, a};
  endfunction

  task automatic step();
    @(negedge clk);
    if (freeze) frz_cnt++;
    if (bus.mem_req) begin
      last_addr  = bus.mem_addr;
      last_wdata = bus.mem_wdata;
      last_we    = bus.mem_we;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wb, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] v, input logic [4:0] d);
    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    alu_res_in = a; st_val_in = v; dest_in = d;
    e_wb = wb; e_rd = r; e_alu = a; e_dest = d;
  endtask

  task automatic reset_dut();
    chk_en = 1'b0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    bus.mem_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    m_ld = '0; m_err = 1'b0;
    e_freeze = 1'b0; e_req = 1'b0; e_ld = '0; e_err = 1'b0;
    chk_en = 1'b1;
    step();
  endtask

  // ack_at: BUSY cycle (1-based) carrying mem_ack; out of 1..TIMEOUT means never.
  task automatic run_instr(input logic wb, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] v,
                           input logic [4:0] d, input int ack_at);
    logic        abort;
    logic [31:0] off;
    abort   = 1'b0;
    off     = a - DATA_BASE;
    m_waddr = off[17:2];
    frz_cnt = 0;
    drive(wb, r, w, a, v, d);
    e_freeze = r | w; e_req = 1'b0; e_ld = m_ld; e_err = m_err;
    step();
    if (!(r | w)) return;
    if (a[1:0] != 2'b00) begin
      m_err = 1'b1; m_ld = '0; abort = 1'b1;
    end else begin
      if (r && w) m_err = 1'b1;
      e_req = 1'b1; e_we = w; e_addr = m_waddr; e_wdata = v; e_err = m_err;
      for (int k = 1; k <= TIMEOUT; k++) begin
        if (k == ack_at) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = w ? $urandom : rd_mem(m_waddr);
        end
        step();
        bus.mem_ack = 1'b0;
        if (k == ack_at) begin
          if (w) mem_model[m_waddr] = v;
          else   m_ld = rd_mem(m_waddr);
          break;
        end
      end
      if (ack_at < 1 || ack_at > TIMEOUT) begin
        m_err = 1'b1; m_ld = '0; abort = 1'b1;
      end
    end
    e_freeze = 1'b0; e_req = 1'b0; e_ld = m_ld; e_err = m_err;
    e_wb = wb & ~(abort & r);
    step();
  endtask

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    reset_dut();

    run_instr(1'b1, 1'b0, 1'b0, 32'h0000_00AA, 32'h0, 5'd7, 0);
    check("nonmem_frz_cycles", 32'(frz_cnt), 32'd0);

    run_instr(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 5'd0, 2);
    check("st_model_waddr", 32'(m_waddr), 32'd2);
    check("st_addr",  32'(last_addr), 32'd2);
    check("st_we",    32'(last_we),   32'd1);
    check("st_wdata", last_wdata,     32'hDEADBEEF);
    check("st_frz_cycles", 32'(frz_cnt), 32'd3);

    mem_model[16'd0] = 32'h12345678;
    run_instr(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 5'd9, 1);
    check("ld_data", load_data, 32'h12345678);
    check("ld_frz_cycles", 32'(frz_cnt), 32'd2);

    run_instr(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 5'd4, 0);
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_load_data", load_data, 32'd0);
    check("to_frz_cycles", 32'(frz_cnt), 32'(TIMEOUT + 1));

    reset_dut();
    run_instr(1'b1, 1'b1, 1'b0, 32'd1026, 32'h0, 5'd5, 1);
    check("mis_bus_err", 32'(bus_err), 32'd1);
    check("mis_frz_cycles", 32'(frz_cnt), 32'd1);

    // Reset lands in the third BUSY cycle of a load that never gets acked.
    reset_dut();
    drive(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 5'd3);
    e_freeze = 1'b1; e_req = 1'b0; e_ld = m_ld; e_err = m_err;
    step();
    e_req = 1'b1; e_we = 1'b0; e_addr = 16'd2; e_wdata = 32'h0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    e_freeze = 1'b0; e_req = 1'b0; e_ld = '0; e_err = 1'b0;
    m_ld = '0; m_err = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
    step();
    bus.mem_ack = 1'b0;
    step();
    check("rst_late_ack_ld", load_data, 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic        r, w;
      logic [31:0] a;
      int          op, ack;
      op = $urandom_range(0, 9);
      r  = (op >= 2 && op <= 5) || op == 9;
      w  = (op >= 6);
      a  = 32'(DATA_BASE) + 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) a = 32'(DATA_BASE - 4);
      ack = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 5);
      run_instr(1'($urandom), r, w, a, $urandom, 5'($urandom), ack);
    end

    chk_en = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
